alu_flags: RTL and testbench
============================

Name: alu_flags

Overview:
- Status-register (P) unit on the consuming end of the ALU interface.
- Takes per-instruction flag-update requests in the same cycle the ALU op is issued, then aligns them with the ALU's one-cycle-registered result.
- Updates N V D I Z C and feeds carry back to the ALU's ci input, including a same-cycle forward for back-to-back carry chains.
- Also handles flag set/clear, BIT, PLP/RTI load, interrupt I-masking and push formatting.

Parameters:
- RESET_P, 8'h34, P value after reset (I=1; bits 5 and 4 always read 1).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- alu_op_i  in  6  ALU op issued this cycle; bit 3 = adder op
- shift_c_i  in  1  ALU shift carry, valid in the issue cycle only
- alu_out_i  in  8  ALU result, valid one cycle after issue
- sum_c_i  in  1  ALU adder carry-out, valid one cycle after issue
- sum_v_i  in  1  ALU adder overflow, valid one cycle after issue
- upd_nz_i  in  1  update N/Z from ALU result
- upd_c_i  in  1  update C
- upd_v_i  in  1  update V from sum_v_i
- bit_i  in  1  BIT instruction: N=operand[7], V=operand[6], Z from ALU result
- operand_i  in  8  BIT operand, sampled at issue
- set_clr_i  in  3  0=none 1=CLC 2=SEC 3=CLI 4=SEI 5=CLD 6=SED 7=CLV
- load_p_i  in  1  load P from db_i (PLP/RTI)
- db_i  in  8  P load data, sampled at issue
- int_mask_i  in  1  force I=1 (IRQ/NMI/BRK entry)
- push_b_i  in  1  B bit value for p_push_o
- p_o  out  8  current P: {N,V,1,1,D,I,Z,C}
- p_push_o  out  8  {N,V,1,push_b_i,D,I,Z,C}, combinational
- c_o  out  1  carry to ALU ci (forwarded)

Behaviour:
- Reset:
  - synchronous, active-high rst; clock clk.
  - P = RESET_P; p_o = 8'h34.
  - Pipeline request register cleared; any pending request is dropped. rst during T+1 of a request: that request never commits.
- Pipeline:
  - All *_i request inputs, plus alu_op_i[3], shift_c_i, operand_i[7:6] and db_i, are registered at the end of issue cycle T.
  - In T+1 the registered request combines with alu_out_i/sum_c_i/sum_v_i and commits at the end of T+1; visible on p_o in T+2.
  - Requests are issued at most one per cycle; back-to-back issue is fully supported (one commit per cycle, in order).
- Next-state computation, in T+1, lowest to highest priority:
  1. Hold current P.
  2. upd_nz: N=alu_out[7], Z=(alu_out==0).
  3. upd_c: C = op_r[3] ? sum_c_i : shift_c_r.
  4. upd_v: V = sum_v_i.
  5. bit: N=operand_r[7], V=operand_r[6], Z=(alu_out==0). Overrides steps 2 and 4.
  6. set_clr: writes the addressed flag. Overrides the ALU-derived value of the same flag.
  7. int_mask: I=1.
  8. load_p: N,V,D,I,Z,C = db_r[7,6,3,2,1,0]; db bits 5:4 ignored. Overrides everything except int_mask, which still forces I=1.
- Carry forward:
  - c_o = next-state C when the registered request writes C (upd_c, CLC/SEC, or load_p); otherwise the stored C.
  - This lets an op issued in T+1 use the carry of the op issued in T.
  - The combinational path sum_c_i -> c_o is intentional.
- Invariants:
  - p_o bits 5 and 4 are constant 1.
  - D is stored only; no decimal arithmetic here.
  - No request (all strobes 0, set_clr=0): P unchanged indefinitely.

Test Plan:
- Reset mid-request: issue SEC, assert rst in T+1 -> p_o=8'h34 in T+2; C stays 0; c_o=0.
- ADC pair: issue adder op with upd_nz/c/v; in T+1 drive alu_out=8'h80, sum_c=0, sum_v=1 -> p_o=8'hF4 in T+2 (N=1, V=1, Z=0, C=0). Next issue has alu_out=8'h00, sum_c=1 -> Z=1, C=1, N=0, and c_o=1 during that T+1.
- Shift carry: issue op with bit3=0, upd_c, shift_c_i=1 and deassert shift_c_i in T+1 -> C=1; the registered value is used.
- BIT: operand=8'hC0, alu_out=8'h00, current V=0 -> N=1, V=1, Z=1, C unchanged.
- PLP with interrupt: db_i=8'h0F, load_p -> p_o=8'h3F. Repeat with int_mask_i=1 and db_i=8'h00 -> p_o=8'h34.
- Priority/throughput: SEC issued with upd_c while sum_c=0 -> C=1. Then CLC, SEC, CLC issued on consecutive cycles -> C sequence 0,1,0 on successive cycles; c_o matches one cycle earlier.

Source files
------------

// File: rtl/alu_flags.sv
// Processor status register (P) on the consuming end of the ALU.
// Flag-update requests are registered at issue and merged with the ALU's registered result one cycle later.
module alu_flags #(
  parameter logic [7:0] RESET_P = 8'h34
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] alu_op_i,
  input  logic       shift_c_i,
  input  logic [7:0] alu_out_i,
  input  logic       sum_c_i,
  input  logic       sum_v_i,
  input  logic       upd_nz_i,
  input  logic       upd_c_i,
  input  logic       upd_v_i,
  input  logic       bit_i,
  input  logic [7:0] operand_i,
  input  logic [2:0] set_clr_i,
  input  logic       load_p_i,
  input  logic [7:0] db_i,
  input  logic       int_mask_i,
  input  logic       push_b_i,
  output logic [7:0] p_o,
  output logic [7:0] p_push_o,
  output logic       c_o
);

  typedef enum logic [2:0] {
    SC_NONE = 3'd0,
    SC_CLC  = 3'd1,
    SC_SEC  = 3'd2,
    SC_CLI  = 3'd3,
    SC_SEI  = 3'd4,
    SC_CLD  = 3'd5,
    SC_SED  = 3'd6,
    SC_CLV  = 3'd7
  } set_clr_e;

  typedef struct packed {
    logic       upd_nz;
    logic       upd_c;
    logic       upd_v;
    logic       bit_op;
    logic       load_p;
    logic       int_mask;
    set_clr_e   set_clr;
    logic       adder;
    logic       shift_c;
    logic [1:0] operand;
    logic [5:0] db;
  } req_t;

  req_t       req_d, req_q;
  logic [7:0] p_d, p_q;
  logic       alu_zero;
  logic       writes_c;
  logic       unused_inputs;

  assign unused_inputs = ^{alu_op_i[5:4], alu_op_i[2:0], operand_i[5:0], db_i[5:4]};

  always_comb begin
    req_d          = '0;
    req_d.upd_nz   = upd_nz_i;
    req_d.upd_c    = upd_c_i;
    req_d.upd_v    = upd_v_i;
    req_d.bit_op   = bit_i;
    req_d.load_p   = load_p_i;
    req_d.int_mask = int_mask_i;
    req_d.set_clr  = set_clr_e'(set_clr_i);
    req_d.adder    = alu_op_i[3];
    req_d.shift_c  = shift_c_i;
    req_d.operand  = operand_i[7:6];
    req_d.db       = {db_i[7:6], db_i[3:0]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q <= '0;
    end else begin
      req_q <= req_d;
    end
  end

  assign alu_zero = (alu_out_i == 8'h00);

  // Later assignments win, so the order below is the flag priority.
  always_comb begin
    p_d = p_q;
    if (req_q.upd_nz) begin
      p_d[7] = alu_out_i[7];
      p_d[1] = alu_zero;
    end
    if (req_q.upd_c) begin
      p_d[0] = req_q.adder ? sum_c_i : req_q.shift_c;
    end
    if (req_q.upd_v) begin
      p_d[6] = sum_v_i;
    end
    if (req_q.bit_op) begin
      p_d[7] = req_q.operand[1];
      p_d[6] = req_q.operand[0];
      p_d[1] = alu_zero;
    end
    case (req_q.set_clr)
      SC_CLC:  p_d[0] = 1'b0;
      SC_SEC:  p_d[0] = 1'b1;
      SC_CLI:  p_d[2] = 1'b0;
      SC_SEI:  p_d[2] = 1'b1;
      SC_CLD:  p_d[3] = 1'b0;
      SC_SED:  p_d[3] = 1'b1;
      SC_CLV:  p_d[6] = 1'b0;
      default: ;
    endcase
    if (req_q.load_p) begin
      p_d[7:6] = req_q.db[5:4];
      p_d[3:0] = req_q.db[3:0];
    end
    if (req_q.int_mask) begin
      p_d[2] = 1'b1;
    end
    p_d[5:4] = 2'b11;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_q <= RESET_P | 8'h30;
    end else begin
      p_q <= p_d;
    end
  end

  // Forward the carry being written this cycle so a chained op issued now sees it.
  always_comb begin
    writes_c = req_q.upd_c || req_q.load_p ||
               (req_q.set_clr == SC_CLC) || (req_q.set_clr == SC_SEC);
    c_o      = (writes_c && !rst) ? p_d[0] : p_q[0];
  end

  assign p_o      = p_q;
  assign p_push_o = {p_q[7:6], 1'b1, push_b_i, p_q[3:0]};

endmodule

// File: tb/tb_alu_flags.sv
// Scoreboard bench for alu_flags: a reference model pushes expected P and carry at issue;
// they are popped and compared when the DUT is due to show them.
module tb_alu_flags;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] alu_op_i;
  logic       shift_c_i;
  logic [7:0] alu_out_i;
  logic       sum_c_i;
  logic       sum_v_i;
  logic       upd_nz_i;
  logic       upd_c_i;
  logic       upd_v_i;
  logic       bit_i;
  logic [7:0] operand_i;
  logic [2:0] set_clr_i;
  logic       load_p_i;
  logic [7:0] db_i;
  logic       int_mask_i;
  logic       push_b_i;
  logic [7:0] p_o;
  logic [7:0] p_push_o;
  logic       c_o;

  alu_flags #(.RESET_P(8'h34)) dut (
    .clk(clk), .rst(rst), .alu_op_i(alu_op_i), .shift_c_i(shift_c_i),
    .alu_out_i(alu_out_i), .sum_c_i(sum_c_i), .sum_v_i(sum_v_i),
    .upd_nz_i(upd_nz_i), .upd_c_i(upd_c_i), .upd_v_i(upd_v_i), .bit_i(bit_i),
    .operand_i(operand_i), .set_clr_i(set_clr_i), .load_p_i(load_p_i),
    .db_i(db_i), .int_mask_i(int_mask_i), .push_b_i(push_b_i),
    .p_o(p_o), .p_push_o(p_push_o), .c_o(c_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       op3;
    logic       shift_c;
    logic       upd_nz;
    logic       upd_c;
    logic       upd_v;
    logic       bit_op;
    logic       int_mask;
    logic       load_p;
    logic       push_b;
    logic [2:0] set_clr;
    logic [7:0] operand;
    logic [7:0] db;
    logic [7:0] alu_out;
    logic       sum_c;
    logic       sum_v;
  } txn_t;

  logic [7:0] exp_p_q[$];
  logic       exp_c_q[$];
  int         total = 0;
  int         bad = 0;
  logic [7:0] m_p;
  logic [7:0] m_vis;
  txn_t       prev;
  logic       v1;
  logic       v2;

  task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic txn_t idleTxn();
    txn_t t;
    t = '{default: '0};
    return t;
  endfunction

  function automatic logic [7:0] modelNext(input logic [7:0] p, input txn_t t);
    logic [7:0] n;
    n = p;
    if (t.upd_nz) begin
      n[7] = t.alu_out[7];
      n[1] = (t.alu_out == 8'h00);
    end
    if (t.upd_c) n[0] = t.op3 ? t.sum_c : t.shift_c;
    if (t.upd_v) n[6] = t.sum_v;
    if (t.bit_op) begin
      n[7] = t.operand[7];
      n[6] = t.operand[6];
      n[1] = (t.alu_out == 8'h00);
    end
    case (t.set_clr)
      3'd1: n[0] = 1'b0;
      3'd2: n[0] = 1'b1;
      3'd3: n[2] = 1'b0;
      3'd4: n[2] = 1'b1;
      3'd5: n[3] = 1'b0;
      3'd6: n[3] = 1'b1;
      3'd7: n[6] = 1'b0;
      default: ;
    endcase
    if (t.load_p) begin
      n[7:6] = t.db[7:6];
      n[3:0] = t.db[3:0];
    end
    if (t.int_mask) n[2] = 1'b1;
    n[5:4] = 2'b11;
    return n;
  endfunction

  // One clock cycle: issue cur (if valid), feed ALU results of the previous issue, check at negedge.
  task automatic applyStimulus(input txn_t cur, input logic cur_v);
    logic exp_c;
    txn_t d;
    d = cur_v ? cur : idleTxn();
    alu_op_i   = {2'b01, d.op3, 3'b010};
    shift_c_i  = d.shift_c;
    upd_nz_i   = d.upd_nz;
    upd_c_i    = d.upd_c;
    upd_v_i    = d.upd_v;
    bit_i      = d.bit_op;
    operand_i  = d.operand;
    set_clr_i  = d.set_clr;
    load_p_i   = d.load_p;
    db_i       = d.db;
    int_mask_i = d.int_mask;
    push_b_i   = cur.push_b;
    alu_out_i  = v1 ? prev.alu_out : 8'h00;
    sum_c_i    = v1 ? prev.sum_c : 1'b0;
    sum_v_i    = v1 ? prev.sum_v : 1'b0;
    if (cur_v) begin
      m_p = modelNext(m_p, cur);
      exp_p_q.push_back(m_p);
      exp_c_q.push_back(m_p[0]);
    end
    @(negedge clk);
    if (v2) begin
      if (exp_p_q.size() == 0) checkOutput("p_queue_empty", 8'd0, 8'd1);
      else m_vis = exp_p_q.pop_front();
    end
    checkOutput("p_o", p_o, m_vis);
    checkOutput("p_push_o", p_push_o, {m_vis[7:6], 1'b1, push_b_i, m_vis[3:0]});
    exp_c = m_vis[0];
    if (v1) begin
      if (exp_c_q.size() == 0) checkOutput("c_queue_empty", 8'd0, 8'd1);
      else exp_c = exp_c_q.pop_front();
    end
    checkOutput("c_o", {7'd0, c_o}, {7'd0, exp_c});
    @(posedge clk);
    #1;
    v2 = v1;
    v1 = cur_v;
    if (cur_v) prev = cur;
  endtask

  task automatic idleCycles(input int n);
    for (int k = 0; k < n; k++) applyStimulus(idleTxn(), 1'b0);
  endtask

  task automatic setClr(input logic [2:0] code);
    txn_t t;
    t = idleTxn();
    t.set_clr = code;
    applyStimulus(t, 1'b1);
  endtask

  initial begin
    txn_t t;
    rst = 1'b1;
    applyStimulusInit();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    m_p = 8'h34; m_vis = 8'h34; v1 = 1'b0; v2 = 1'b0;
    prev = idleTxn();
    checkOutput("reset_p", p_o, 8'h34);
    checkOutput("reset_c", {7'd0, c_o}, 8'd0);
    idleCycles(2);

    // ADC pair, back to back
    t = idleTxn(); t.op3 = 1; t.upd_nz = 1; t.upd_c = 1; t.upd_v = 1;
    t.alu_out = 8'h80; t.sum_c = 0; t.sum_v = 1;
    applyStimulus(t, 1'b1);
    t.alu_out = 8'h00; t.sum_c = 1; t.sum_v = 0;
    applyStimulus(t, 1'b1);
    idleCycles(2);
    checkOutput("adc_pair", p_o, 8'h37);

    // Shift carry registered at issue, deasserted afterwards
    setClr(3'd1);
    t = idleTxn(); t.op3 = 0; t.upd_c = 1; t.shift_c = 1;
    applyStimulus(t, 1'b1);
    idleCycles(2);
    checkOutput("shift_c", p_o, 8'h37);

    // BIT
    t = idleTxn(); t.bit_op = 1; t.operand = 8'hC0; t.alu_out = 8'h00;
    applyStimulus(t, 1'b1);
    idleCycles(2);
    checkOutput("bit", p_o, 8'hF7);

    // PLP, then PLP with interrupt masking
    t = idleTxn(); t.load_p = 1; t.db = 8'h0F;
    applyStimulus(t, 1'b1);
    idleCycles(2);
    checkOutput("plp", p_o, 8'h3F);
    t = idleTxn(); t.load_p = 1; t.db = 8'h00; t.int_mask = 1;
    applyStimulus(t, 1'b1);
    idleCycles(2);
    checkOutput("plp_int", p_o, 8'h34);

    // SEC over ALU carry, then CLC/SEC/CLC back to back
    t = idleTxn(); t.set_clr = 3'd2; t.upd_c = 1; t.op3 = 1; t.sum_c = 0;
    applyStimulus(t, 1'b1);
    setClr(3'd1);
    setClr(3'd2);
    setClr(3'd1);
    idleCycles(2);
    checkOutput("clc_sec_clc", p_o, 8'h34);

    // Random mixed traffic
    for (int i = 0; i < 80; i++) begin
      t = idleTxn();
      t.op3      = 1'($urandom);
      t.shift_c  = 1'($urandom);
      t.upd_nz   = 1'($urandom);
      t.upd_c    = 1'($urandom);
      t.upd_v    = 1'($urandom);
      t.bit_op   = ($urandom_range(0, 5) == 0);
      t.int_mask = ($urandom_range(0, 7) == 0);
      t.load_p   = ($urandom_range(0, 6) == 0);
      t.push_b   = 1'($urandom);
      t.set_clr  = 3'($urandom);
      t.operand  = 8'($urandom);
      t.db       = 8'($urandom);
      t.alu_out  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      t.sum_c    = 1'($urandom);
      t.sum_v    = 1'($urandom);
      applyStimulus(t, ($urandom_range(0, 3) != 0));
    end
    idleCycles(3);

    // Reset during T+1 of a SEC: the request must never commit
    setClr(3'd2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    set_clr_i = 3'd0;
    @(negedge clk);
    checkOutput("rst_mid_p", p_o, 8'h34);
    checkOutput("rst_mid_c", {7'd0, c_o}, 8'd0);
    @(posedge clk);
    #1;
    checkOutput("rst_mid_p_later", p_o, 8'h34);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  task automatic applyStimulusInit();
    alu_op_i = '0; shift_c_i = 0; alu_out_i = '0; sum_c_i = 0; sum_v_i = 0;
    upd_nz_i = 0; upd_c_i = 0; upd_v_i = 0; bit_i = 0; operand_i = '0;
    set_clr_i = '0; load_p_i = 0; db_i = '0; int_mask_i = 0; push_b_i = 0;
  endtask

endmodule
